// File: rtl/cpu_pkg.sv
// Shared encodings for the memory arbiter: FSM states and transfer owners.
package cpu_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } state_e;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_IF   = 2'd1,
        OWN_D    = 2'd2
    } owner_e;

endpackage

// File: rtl/mem_arbiter_arb_prio.sv
// Fixed data-over-fetch priority with a starvation counter that forces
// fetch to win after STARVE_LIMIT consecutive lost arbitrations.
module arb_prio
    import cpu_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       if_req_i,
    input  logic       d_req_i,
    input  logic       if_xfer_i,
    input  logic       d_xfer_i,
    output logic [1:0] winner_o
);

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    logic [3:0] starve_q;
    logic [3:0] starve_d;
    logic       fetch_force;

    assign fetch_force = if_req_i && (starve_q == LIMIT);

    always_comb begin
        winner_o = OWN_NONE;
        if (d_req_i && !fetch_force) begin
            winner_o = OWN_D;
        end else if (if_req_i) begin
            winner_o = OWN_IF;
        end
    end

    // Only data transfers completed while fetch is waiting count as starvation.
    always_comb begin
        starve_d = starve_q;
        if (!if_req_i || if_xfer_i) begin
            starve_d = '0;
        end else if (d_xfer_i && (starve_q != LIMIT)) begin
            starve_d = starve_q + 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            starve_q <= '0;
        end else begin
            starve_q <= starve_d;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Two-requester memory arbiter: fetch and load/store ports share one
// single-cycle-latency memory, with selection locked while memory stalls.
module mem_arbiter
    import cpu_pkg::*;
#(
    parameter int ADDR_W       = 16,
    parameter int DATA_W       = 16,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ready,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              stall
);

    state_e     state_q, state_d;
    owner_e     hold_q, hold_d;
    owner_e     resp_q, resp_d;
    owner_e     sel;
    logic [1:0] winner;
    logic       xfer;

    arb_prio #(
        .STARVE_LIMIT(STARVE_LIMIT)
    ) u_prio (
        .clk       (clk),
        .rst_n     (rst_n),
        .if_req_i  (if_req),
        .d_req_i   (d_req),
        .if_xfer_i (if_gnt),
        .d_xfer_i  (d_gnt),
        .winner_o  (winner)
    );

    // Reset masks selection so nothing is presented or granted in that cycle.
    always_comb begin
        sel = OWN_NONE;
        if (rst_n) begin
            sel = (state_q == ST_HOLD) ? hold_q : owner_e'(winner);
        end
    end

    always_comb begin
        mem_en    = (sel != OWN_NONE);
        mem_we    = (sel == OWN_D) && d_we;
        mem_addr  = '0;
        mem_wdata = '0;
        if (sel == OWN_D) begin
            mem_addr  = d_addr;
            mem_wdata = d_wdata;
        end else if (sel == OWN_IF) begin
            mem_addr  = if_addr;
        end
    end

    assign xfer      = mem_en && mem_ready;
    assign if_gnt    = xfer && (sel == OWN_IF);
    assign d_gnt     = xfer && (sel == OWN_D);
    assign stall     = if_req && !if_gnt;
    assign if_rvalid = rst_n && (resp_q == OWN_IF);
    assign d_rvalid  = rst_n && (resp_q == OWN_D);
    assign rdata     = (if_rvalid || d_rvalid) ? mem_rdata : '0;

    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        resp_d  = (xfer && !mem_we) ? sel : OWN_NONE;
        if (state_q == ST_IDLE) begin
            if (mem_en && !mem_ready) begin
                state_d = ST_HOLD;
                hold_d  = sel;
            end
        end else if (mem_ready) begin
            state_d = ST_IDLE;
            hold_d  = OWN_NONE;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            hold_q  <= OWN_NONE;
            resp_q  <= OWN_NONE;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            resp_q  <= resp_d;
        end
    end

endmodule
